mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter ADDR_W, default 2, sets the memory address width (2^ADDR_W locations).
REQ-002 Parameter DATA_W, default 8, sets the data width.
REQ-003 Parameter READ_LAT, default 1, range 1..4, gives the cycles from the edge that samples mem_rd_en to valid mem_r_data.
REQ-004 Parameter INIT_EN, default 1; when 1, memory is zero-filled after reset.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  1  request offered.
REQ-008 req_ready  out  1  request accepted on an edge where req_valid && req_ready.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  request address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  read data available.
REQ-013 rsp_ready  in  1  consumer takes the response on an edge where rsp_valid && rsp_ready.
REQ-014 rsp_rdata  out  DATA_W  read data.
REQ-015 mem_addr / mem_wr_en / mem_rd_en / mem_w_data  out  ADDR_W/1/1/DATA_W  downstream memory port.
REQ-016 mem_r_data  in  DATA_W  memory read data.
REQ-017 init_done  out  1  high once zero-fill is complete, or immediately after reset when INIT_EN=0.

Function
REQ-018 FSM states SHALL be INIT, IDLE, RD_WAIT and RSP.
REQ-019 All outputs SHALL be registered; no combinational path SHALL exist from req_* or rsp_ready to any output.
REQ-020 INIT SHALL drive mem_wr_en=1 and mem_w_data=0, with mem_addr stepping 0..2^ADDR_W-1, one address per cycle; after the last address it SHALL enter IDLE and set init_done.
REQ-021 req_ready SHALL be 1 only in IDLE.
REQ-022 A write accepted at edge E SHALL drive mem_wr_en=1 with mem_addr/mem_w_data for exactly the cycle after E, produce no response, and leave the FSM in IDLE, so back-to-back writes run at one per cycle.
REQ-023 A read accepted at edge E SHALL drive mem_rd_en=1 for exactly the cycle after E and enter RD_WAIT.
REQ-024 In RD_WAIT, mem_r_data SHALL be captured into rsp_rdata at edge E+1+READ_LAT; at that edge rsp_valid SHALL go to 1 and the FSM SHALL enter RSP.
REQ-025 In RSP, rsp_valid and rsp_rdata SHALL hold stable until rsp_valid && rsp_ready; on that edge the FSM SHALL enter IDLE and rsp_valid SHALL go to 0.
REQ-026 If rsp_ready is already 1 when rsp_valid rises, the handshake SHALL complete at the next edge; req_ready SHALL be 1 in the cycle after the handshake.
REQ-027 mem_wr_en and mem_rd_en SHALL never both be 1; both SHALL be 0 in every cycle without a scheduled access.
REQ-028 Requests offered outside IDLE SHALL be ignored, and the requester SHALL hold them until accepted.
REQ-029 The INIT address counter SHALL wrap at the address-field width; the last address SHALL be 2^ADDR_W-1 with no overrun write.

Reset
REQ-030 While rst=0 at an edge, the block SHALL set: req_ready=0, rsp_valid=0, rsp_rdata=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_w_data=0 and init_done=0.
REQ-031 After rst returns to 1, the FSM SHALL enter INIT if INIT_EN=1, otherwise IDLE with init_done=1.
REQ-032 Reset in any state, including RD_WAIT or RSP, SHALL drop the pending response and restart INIT.

Structure
REQ-033 Package mem_ctrl_pkg SHALL hold the state enum and the default ADDR_W/DATA_W constants.
REQ-034 Sub-module rd_lat_pipe SHALL be a READ_LAT-deep shift register of the mem_rd_en pulse that generates the capture strobe.

Verification
REQ-035 Release reset with INIT_EN=1 -> four write cycles to addr 0,1,2,3 with data 0x00, then init_done=1 and req_ready=1.
REQ-036 Write addr 2 = 0x04, then read addr 2 -> rsp_valid 2 edges after read accept with rsp_rdata=0x04; read addr 3 -> 0x00.
REQ-037 Four consecutive writes (addr 0..3 = 0x11, 0x22, 0x33, 0x44) -> mem_wr_en high for 4 consecutive cycles; read-back returns the same values.
REQ-038 Read accepted with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; a single handshake, then IDLE.
REQ-039 rst=0 while in RSP -> rsp_valid=0 at the next edge and no stale response after restart; INIT repeats.
REQ-040 Check throughout: mem_wr_en && mem_rd_en never true, and no access is issued while init_done=0 other than the INIT writes.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the memory request controller.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RSP
    } state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Delays the single-cycle mem_rd_en pulse by READ_LAT edges to produce the
// strobe that marks the edge at which mem_r_data is valid for capture.
module rd_lat_pipe #(
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_pulse,
    output logic cap_strobe
);

    logic [READ_LAT-1:0] pipe_reg;
    logic [READ_LAT-1:0] pipe_next;

    genvar gi;
    generate
        for (gi = 0; gi < READ_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign pipe_next[gi] = rd_pulse;
            end else begin : g_tail
                assign pipe_next[gi] = pipe_reg[gi-1];
            end
        end
    endgenerate

    // Clearing on reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    assign cap_strobe = pipe_reg[READ_LAT-1];

endmodule

// File: rtl/mem_req_ctrl.sv
// Request/response front end for a simple synchronous memory: zero-fills the
// memory after reset, then serves one write per cycle or one read at a time.
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1,
    parameter int INIT_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg;
    logic [ADDR_W-1:0] init_cnt_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_wr_en_reg;
    logic              mem_rd_en_reg;
    logic [DATA_W-1:0] mem_w_data_reg;
    logic              init_done_reg;
    logic              cap_strobe;

    rd_lat_pipe #(
        .READ_LAT (READ_LAT)
    ) u_rd_lat_pipe (
        .clk        (clk),
        .rst        (rst),
        .rd_pulse   (mem_rd_en_reg),
        .cap_strobe (cap_strobe)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= (INIT_EN != 0) ? INIT : IDLE;
            init_cnt_reg   <= '0;
            req_ready_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            mem_addr_reg   <= '0;
            mem_wr_en_reg  <= 1'b0;
            mem_rd_en_reg  <= 1'b0;
            mem_w_data_reg <= '0;
            init_done_reg  <= 1'b0;
        end else begin
            // Memory strobes are single-cycle pulses unless re-armed below.
            mem_wr_en_reg <= 1'b0;
            mem_rd_en_reg <= 1'b0;

            case (state_reg)
                INIT: begin
                    // Leave only once the last address has been on the bus.
                    if (mem_wr_en_reg && (mem_addr_reg == LAST_ADDR)) begin
                        state_reg     <= IDLE;
                        init_done_reg <= 1'b1;
                        req_ready_reg <= 1'b1;
                    end else begin
                        mem_wr_en_reg  <= 1'b1;
                        mem_addr_reg   <= init_cnt_reg;
                        mem_w_data_reg <= '0;
                        init_cnt_reg   <= init_cnt_reg + 1'b1;
                    end
                end

                IDLE: begin
                    init_done_reg <= 1'b1;
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        mem_addr_reg <= req_addr;
                        if (req_we) begin
                            mem_wr_en_reg  <= 1'b1;
                            mem_w_data_reg <= req_wdata;
                        end else begin
                            mem_rd_en_reg <= 1'b1;
                            req_ready_reg <= 1'b0;
                            state_reg     <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (cap_strobe) begin
                        rsp_rdata_reg <= mem_r_data;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_valid_reg && rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_rdata  = rsp_rdata_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wr_en  = mem_wr_en_reg;
    assign mem_rd_en  = mem_rd_en_reg;
    assign mem_w_data = mem_w_data_reg;
    assign init_done  = init_done_reg;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a one-cycle-latency memory model.
module tb_mem_req_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [1:0] mem_addr;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_w_data;
    logic [7:0] mem_r_data;
    logic       init_done;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [7:0] mem_model [4];

    always #5 clk = ~clk;

    mem_req_ctrl #(
        .ADDR_W   (2),
        .DATA_W   (8),
        .READ_LAT (1),
        .INIT_EN  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data),
        .init_done  (init_done)
    );

    // Memory samples mem_rd_en at an edge and presents data one cycle later.
    always @(posedge clk) begin
        if (mem_wr_en) mem_model[mem_addr] <= mem_w_data;
        if (mem_rd_en) mem_r_data <= mem_model[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("wr_rd_excl", {31'b0, mem_wr_en & mem_rd_en}, 32'd0);
            if (!init_done) begin
                check_eq("init_no_rd", mem_rd_en, 0);
                if (mem_wr_en) check_eq("init_wdata", mem_w_data, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check_eq("req_ready_wait", req_ready, 1);
    endtask

    task automatic init_seq();
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("init_wr_en", mem_wr_en, 1);
            check_eq("init_addr", mem_addr, i);
            check_eq("init_done_lo", init_done, 0);
            check_eq("init_rsp_valid", rsp_valid, 0);
        end
        step();
        check_eq("init_done", init_done, 1);
        check_eq("init_ready", req_ready, 1);
        check_eq("init_wr_off", mem_wr_en, 0);
        $display("INIT zero-fill complete at %0t", $time);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        wait_ready();
        step();
        req_valid = 1'b0;
        check_eq("wr_en", mem_wr_en, 1);
        check_eq("wr_addr", mem_addr, a);
        check_eq("wr_data", mem_w_data, d);
        $display("WR addr=%0d data=%02h", a, d);
    endtask

    // rsp_ready is already high when rsp_valid rises.
    task automatic do_read(input logic [1:0] a, input logic [7:0] exp);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        wait_ready();
        step();
        req_valid = 1'b0;
        check_eq("rd_en", mem_rd_en, 1);
        check_eq("rd_addr", mem_addr, a);
        check_eq("rd_ready_lo", req_ready, 0);
        check_eq("rd_rsp_early0", rsp_valid, 0);
        step();
        check_eq("rd_en_pulse", mem_rd_en, 0);
        check_eq("rd_rsp_early1", rsp_valid, 0);
        step();
        check_eq("rd_rsp_valid", rsp_valid, 1);
        check_eq("rd_rdata", rsp_rdata, exp);
        step();
        check_eq("rd_rsp_done", rsp_valid, 0);
        check_eq("rd_ready_back", req_ready, 1);
        rsp_ready = 1'b0;
        $display("RD addr=%0d data=%02h expected=%02h", a, rsp_rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wd;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) step();
        mon_en = 1'b1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_wr_en", mem_wr_en, 0);
        check_eq("rst_rd_en", mem_rd_en, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_w_data", mem_w_data, 0);
        check_eq("rst_init_done", init_done, 0);

        rst = 1'b1;
        init_seq();

        do_write(2'd2, 8'h04);
        do_read(2'd2, 8'h04);
        do_read(2'd3, 8'h00);

        // Back-to-back writes: one per cycle with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            wd = 8'(8'h11 * (i + 1));
            req_valid = 1'b1; req_we = 1'b1; req_addr = 2'(i); req_wdata = wd;
            if (i == 0) wait_ready();
            step();
            check_eq("b2b_wr_en", mem_wr_en, 1);
            check_eq("b2b_addr", mem_addr, i);
            check_eq("b2b_data", mem_w_data, wd);
            $display("WR addr=%0d data=%02h (burst)", i, wd);
        end
        req_valid = 1'b0;
        step();
        check_eq("b2b_wr_off", mem_wr_en, 0);
        for (int i = 0; i < 4; i++) begin
            wd = 8'(8'h11 * (i + 1));
            do_read(2'(i), wd);
        end

        // Back-pressured response, with a write held pending meanwhile.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd1;
        wait_ready();
        step();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = 8'hEE;
        step();
        step();
        check_eq("hold_rsp_valid", rsp_valid, 1);
        check_eq("hold_rdata", rsp_rdata, 8'h22);
        check_eq("hold_no_wr", mem_wr_en, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_stable", rsp_rdata, 8'h22);
            check_eq("hold_ready_lo", req_ready, 0);
            check_eq("hold_ignored", mem_wr_en, 0);
        end
        rsp_ready = 1'b1;
        step();
        check_eq("hs_valid_lo", rsp_valid, 0);
        check_eq("hs_ready_hi", req_ready, 1);
        check_eq("hs_no_wr_yet", mem_wr_en, 0);
        rsp_ready = 1'b0;
        step();
        check_eq("pend_wr_en", mem_wr_en, 1);
        check_eq("pend_wr_addr", mem_addr, 0);
        check_eq("pend_wr_data", mem_w_data, 8'hEE);
        check_eq("single_hs", rsp_valid, 0);
        req_valid = 1'b0;
        $display("RD addr=1 data=%02h held 5 cycles; WR addr=0 data=EE after", 8'h22);
        do_read(2'd0, 8'hEE);

        // Reset while a response is waiting.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd3;
        wait_ready();
        step();
        req_valid = 1'b0;
        step();
        step();
        check_eq("pre_rst_valid", rsp_valid, 1);
        check_eq("pre_rst_rdata", rsp_rdata, 8'h44);
        rst = 1'b0;
        step();
        check_eq("rst_rsp_drop", rsp_valid, 0);
        check_eq("rst_rdata_clr", rsp_rdata, 0);
        check_eq("rst2_ready", req_ready, 0);
        check_eq("rst2_init_done", init_done, 0);
        $display("RST asserted in RSP at %0t", $time);
        rst = 1'b1;
        init_seq();
        do_read(2'd3, 8'h00);
        do_read(2'd2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
